// File: rtl/datapath_control_sequencer.sv
// datapath_control_sequencer: decodes 32-bit instructions into registered regfile/ALU control words.
// Optional build macro SEQ_FLAGS_EN latches datapath Status into flags after ALU/CMP ops.
`default_nettype none

module datapath_control_sequencer #(
  parameter logic [4:0] FS_ADD = 5'b01000,
  parameter logic [4:0] FS_SUB = 5'b01010,
  parameter logic [4:0] ZREG   = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic        W,
  output logic        EN_ALU,
  output logic        EN_B,
  output logic        K_SEL,
  output logic        C0,
  output logic [4:0]  SA,
  output logic [4:0]  SB,
  output logic [4:0]  DA,
  output logic [4:0]  FS,
  output logic [63:0] K,
  input  logic [3:0]  Status,
  output logic [3:0]  flags,
  output logic        busy,
  output logic        illegal
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CLR  = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [4:0]  clr_end;

  logic [2:0]  op;
  logic [4:0]  rd, rn, rm, fn;
  logic        c0_bit;
  logic [63:0] imm_k;
  logic        accept;
  logic        unused_instr;

  assign op     = instr[31:29];
  assign rd     = instr[28:24];
  assign rn     = instr[23:19];
  assign rm     = instr[18:14];
  assign fn     = instr[13:9];
  assign c0_bit = instr[8];
  assign imm_k  = {48'd0, instr[18:3]} << {instr[2:1], 4'b0000};
  assign unused_instr = instr[0];

  assign accept      = instr_valid && (state == S_IDLE);
  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      W       <= 1'b0;
      EN_ALU  <= 1'b0;
      EN_B    <= 1'b0;
      K_SEL   <= 1'b0;
      C0      <= 1'b0;
      SA      <= ZREG;
      SB      <= ZREG;
      DA      <= ZREG;
      FS      <= 5'd0;
      K       <= 64'd0;
      illegal <= 1'b0;
      cnt     <= 5'd0;
      clr_end <= 5'd0;
    end else begin
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state  <= S_EXEC;
            W      <= 1'b0;
            EN_ALU <= 1'b0;
            EN_B   <= 1'b0;
            case (op)
              3'b000: begin
                SA <= rn; SB <= rm; DA <= rd; FS <= fn; C0 <= c0_bit;
                K_SEL <= 1'b0; EN_ALU <= 1'b1; W <= 1'b1;
              end
              3'b001: begin
                SA <= rn; DA <= rd; FS <= fn; C0 <= c0_bit; K <= imm_k;
                K_SEL <= 1'b1; EN_ALU <= 1'b1; W <= 1'b1;
              end
              3'b010: begin
                SB <= rm; DA <= rd; EN_B <= 1'b1; W <= 1'b1;
              end
              3'b011: begin
                SA <= ZREG; DA <= rd; FS <= FS_ADD; C0 <= 1'b0; K <= imm_k;
                K_SEL <= 1'b1; EN_ALU <= 1'b1; W <= 1'b1;
              end
              3'b100: begin
                SA <= rn; SB <= rm; FS <= FS_SUB; C0 <= 1'b1;
                K_SEL <= 1'b0; EN_ALU <= 1'b1;
              end
              3'b101: begin
                SA <= ZREG; DA <= rd; FS <= FS_ADD; C0 <= 1'b0; K <= 64'd0;
                K_SEL <= 1'b1; EN_ALU <= 1'b1; W <= 1'b1;
                cnt <= rd; clr_end <= rn; state <= S_CLR;
              end
              default: illegal <= 1'b1;
            endcase
          end
        end
        S_EXEC: begin
          state  <= S_IDLE;
          W      <= 1'b0;
          EN_ALU <= 1'b0;
          EN_B   <= 1'b0;
        end
        S_CLR: begin
          // cnt >= clr_end also terminates at 31, so the counter never wraps
          if (cnt >= clr_end) begin
            state  <= S_IDLE;
            W      <= 1'b0;
            EN_ALU <= 1'b0;
            EN_B   <= 1'b0;
          end else begin
            cnt <= cnt + 5'd1;
            DA  <= cnt + 5'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_FLAGS_EN
  logic       flag_op;
  logic [3:0] flags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_op <= 1'b0;
      flags_q <= 4'd0;
    end else if (accept) begin
      flag_op <= (op == 3'b000) || (op == 3'b001) || (op == 3'b100);
    end else if (state == S_EXEC && flag_op) begin
      flags_q <= Status;
    end
  end

  assign flags = flags_q;
`else
  logic unused_status;
  assign unused_status = ^Status;
  assign flags = 4'b0;
`endif

endmodule

`default_nettype wire
